// File: rtl/trap_ctrl.sv
// trap_ctrl: N-source edge-triggered trap/interrupt controller with sticky pending bits,
// mask, fixed priority (undef first, then lowest IRQ index), handler tracking and timeout.
`default_nettype none

module trap_ctrl #(
   parameter int N_IRQ   = 4,
   parameter int TIMEOUT = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_IRQ-1:0] irq,
   input  logic             undef,
   input  logic             ker,
   input  logic             stall,
   input  logic             mask_we,
   input  logic [N_IRQ-1:0] mask_wdata,
   input  logic             clr_we,
   input  logic [N_IRQ-1:0] clr_mask,
   output logic             Interrupt,
   output logic [7:0]       cause,
   output logic [N_IRQ-1:0] pending,
   output logic             in_handler,
   output logic             err
);

   localparam int              CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      TRAP     = 2'd1,
      WAIT_KER = 2'd2,
      HANDLER  = 2'd3
   } state_t;

   state_t           state;
   state_t           state_nx;
   logic [N_IRQ-1:0] irq_q;
   logic [N_IRQ-1:0] mask;
   logic [N_IRQ-1:0] rise;
   logic [N_IRQ-1:0] eligible;
   logic [N_IRQ-1:0] auto_clr;
   logic [N_IRQ-1:0] clr;
   logic [N_IRQ-1:0] pending_nx;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nx;
   logic [4:0]       win_idx;
   logic [4:0]       acc_idx;
   logic [4:0]       acc_idx_nx;
   logic             acc_irq;
   logic             acc_irq_nx;
   logic [7:0]       cause_nx;
   logic             err_nx;
   logic             intr_nx;
   logic             in_handler_nx;

   assign rise     = irq & ~irq_q;
   assign eligible = pending & mask;

   // Lowest set index wins: scan from the top so the last hit is the smallest index.
   always_comb begin
      win_idx = '0;
      for (int i = N_IRQ - 1; i >= 0; i--) begin
         if (eligible[i]) begin
            win_idx = 5'(i);
         end
      end
   end

   // The accepted IRQ's bit is dropped on the TRAP exit edge; undef traps clear nothing.
   always_comb begin
      auto_clr = '0;
      for (int i = 0; i < N_IRQ; i++) begin
         auto_clr[i] = (state == TRAP) && acc_irq && (acc_idx == 5'(i));
      end
   end

   assign clr        = (clr_we ? clr_mask : '0) | auto_clr;
   assign pending_nx = (pending & ~clr) | rise;

   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      cause_nx   = cause;
      err_nx     = err;
      acc_idx_nx = acc_idx;
      acc_irq_nx = acc_irq;

      case (state)
         IDLE: begin
            if (!stall) begin
               if (undef) begin
                  if (!ker) begin
                     state_nx   = TRAP;
                     cause_nx   = 8'hFF;
                     acc_irq_nx = 1'b0;
                  end else begin
                     err_nx = 1'b1;
                  end
               end else if ((eligible != '0) && !ker) begin
                  state_nx   = TRAP;
                  cause_nx   = {3'b000, win_idx};
                  acc_idx_nx = win_idx;
                  acc_irq_nx = 1'b1;
               end
            end
         end
         TRAP: begin
            state_nx = WAIT_KER;
            cnt_nx   = '0;
         end
         WAIT_KER: begin
            if (ker) begin
               state_nx = HANDLER;
            end else if (cnt == CNT_LAST) begin
               err_nx   = 1'b1;
               state_nx = IDLE;
            end else begin
               cnt_nx = cnt + CNT_W'(1);
            end
         end
         HANDLER: begin
            if (!ker) begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase

      intr_nx       = (state_nx == TRAP);
      in_handler_nx = (state_nx == WAIT_KER) || (state_nx == HANDLER);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         irq_q      <= '0;
         mask       <= '1;
         pending    <= '0;
         cnt        <= '0;
         cause      <= 8'h00;
         err        <= 1'b0;
         acc_idx    <= '0;
         acc_irq    <= 1'b0;
         Interrupt  <= 1'b0;
         in_handler <= 1'b0;
      end else begin
         state      <= state_nx;
         irq_q      <= irq;
         pending    <= pending_nx;
         cnt        <= cnt_nx;
         cause      <= cause_nx;
         err        <= err_nx;
         acc_idx    <= acc_idx_nx;
         acc_irq    <= acc_irq_nx;
         Interrupt  <= intr_nx;
         in_handler <= in_handler_nx;
         if (mask_we) begin
            mask <= mask_wdata;
         end
      end
   end

`ifndef SYNTHESIS
   a_intr_one_cycle: assert property (@(posedge clk) disable iff (!reset)
      Interrupt |=> !Interrupt);
   a_intr_not_in_handler: assert property (@(posedge clk) disable iff (!reset)
      !(Interrupt && in_handler));
`endif

endmodule

`default_nettype wire

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: expected causes are queued at stimulus time and
// popped by a monitor whenever Interrupt is presented.
`default_nettype none

module tb_trap_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] irq;
   logic       undef;
   logic       ker;
   logic       stall;
   logic       mask_we;
   logic [3:0] mask_wdata;
   logic       clr_we;
   logic [3:0] clr_mask;
   logic       Interrupt;
   logic [7:0] cause;
   logic [3:0] pending;
   logic       in_handler;
   logic       err;

   int checks   = 0;
   int failures = 0;
   logic [7:0] exp_q[$];

   trap_ctrl #(.N_IRQ(4), .TIMEOUT(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .irq        (irq),
      .undef      (undef),
      .ker        (ker),
      .stall      (stall),
      .mask_we    (mask_we),
      .mask_wdata (mask_wdata),
      .clr_we     (clr_we),
      .clr_mask   (clr_mask),
      .Interrupt  (Interrupt),
      .cause      (cause),
      .pending    (pending),
      .in_handler (in_handler),
      .err        (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every presented trap must match the oldest queued cause.
   always @(negedge clk) begin
      if (reset === 1'b1 && Interrupt === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_interrupt", {24'h0, cause}, 32'hDEAD);
         end else begin
            chk("trap_cause", {24'h0, cause}, {24'h0, exp_q.pop_front()});
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      irq = '0; undef = 0; ker = 0; stall = 0;
      mask_we = 0; mask_wdata = '0; clr_we = 0; clr_mask = '0;
      reset = 1'b1;
      #1 reset = 1'b0;
      #2;
      chk("rst_interrupt", Interrupt, 0);
      chk("rst_cause", cause, 0);
      chk("rst_pending", pending, 0);
      chk("rst_in_handler", in_handler, 0);
      chk("rst_err", err, 0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      tick();

      // Basic IRQ on source 2
      irq = 4'b0100; exp_q.push_back(8'h02);
      tick(); chk("basic_pending", pending, 4'b0100); chk("basic_no_intr_yet", Interrupt, 0);
      tick(); chk("basic_intr", Interrupt, 1); chk("basic_not_in_handler", in_handler, 0);
      tick(); chk("basic_intr_drop", Interrupt, 0); chk("basic_wait_ker", in_handler, 1);
      chk("basic_autoclr", pending, 0);
      ker = 1; tick(); chk("basic_handler", in_handler, 1);
      ker = 0; irq = 0; tick(); chk("basic_exit", in_handler, 0);

      // Priority: sources 1 and 3 together
      irq = 4'b1010; exp_q.push_back(8'h01); exp_q.push_back(8'h03);
      tick(); chk("prio_pending", pending, 4'b1010);
      tick(); chk("prio_intr1", Interrupt, 1);
      tick(); chk("prio_pending_after", pending, 4'b1000);
      ker = 1; tick();
      ker = 0; tick(); chk("prio_idle", in_handler, 0);
      tick(); chk("prio_intr2", Interrupt, 1);
      tick(); chk("prio_pending_empty", pending, 0);
      ker = 1; tick();
      ker = 0; irq = 0; tick();

      // Undef with irq[0] pending: undef wins and leaves pending untouched
      ker = 1; irq = 4'b0001;
      tick(); chk("undef_pending_setup", pending, 4'b0001); chk("undef_ker_blocks", Interrupt, 0);
      ker = 0; undef = 1; exp_q.push_back(8'hFF);
      tick(); chk("undef_intr", Interrupt, 1);
      undef = 0;
      tick(); chk("undef_keeps_pending", pending, 4'b0001);
      ker = 1; tick();
      clr_we = 1; clr_mask = 4'b0001;
      tick(); chk("handler_clear", pending, 0);
      clr_we = 0; ker = 0; irq = 0;
      tick(); chk("undef_exit", in_handler, 0);

      // Mask, set-beats-clear, mask write enabling a pending bit
      mask_we = 1; mask_wdata = 4'b1110; tick();
      mask_we = 0; irq = 4'b0001;
      tick(); chk("mask_pending", pending, 4'b0001);
      tick(); chk("mask_blocks", Interrupt, 0);
      irq = 0; tick();
      irq = 4'b0001; clr_we = 1; clr_mask = 4'b0001;
      tick(); chk("set_beats_clear", pending, 4'b0001);
      clr_we = 0;
      tick(); chk("mask_still_blocks", Interrupt, 0);
      mask_we = 1; mask_wdata = 4'b1111; exp_q.push_back(8'h00);
      tick(); chk("mask_write_edge", Interrupt, 0);
      mask_we = 0;
      tick(); chk("mask_enable_intr", Interrupt, 1);
      tick(); chk("mask_autoclr", pending, 0);
      ker = 1; tick();
      ker = 0; irq = 0; tick();

      // Stall for three decision edges
      stall = 1; irq = 4'b0010; exp_q.push_back(8'h01);
      tick(); chk("stall_pending", pending, 4'b0010);
      for (int i = 0; i < 3; i++) begin
         tick(); chk("stall_blocks", Interrupt, 0);
      end
      chk("stall_holds_pending", pending, 4'b0010);
      stall = 0;
      tick(); chk("stall_release_intr", Interrupt, 1);
      tick(); chk("stall_autoclr", pending, 0);
      ker = 1; tick();
      ker = 0; irq = 0; tick();

      // Timeout in WAIT_KER
      chk("timeout_err_before", err, 0);
      irq = 4'b0100; exp_q.push_back(8'h02);
      tick(); tick(); chk("timeout_intr", Interrupt, 1);
      irq = 0;
      for (int i = 0; i < 8; i++) begin
         tick(); chk("timeout_waiting", in_handler, 1); chk("timeout_no_err_yet", err, 0);
      end
      tick(); chk("timeout_err", err, 1); chk("timeout_idle", in_handler, 0);

      // Asynchronous reset during TRAP
      irq = 4'b1000; exp_q.push_back(8'h03);
      tick(); tick(); chk("rst_trap_intr", Interrupt, 1);
      @(negedge clk); #1 reset = 1'b0; #1;
      chk("rst_trap_interrupt", Interrupt, 0);
      chk("rst_trap_cause", cause, 0);
      chk("rst_trap_pending", pending, 0);
      chk("rst_trap_err", err, 0);
      chk("rst_trap_in_handler", in_handler, 0);
      irq = 0;
      @(posedge clk); #1 reset = 1'b1;

      // Asynchronous reset during HANDLER
      irq = 4'b0011; exp_q.push_back(8'h00);
      tick(); chk("rst_hdl_pending", pending, 4'b0011);
      tick(); chk("rst_hdl_intr", Interrupt, 1);
      tick(); chk("rst_hdl_pending_left", pending, 4'b0010);
      ker = 1;
      tick(); chk("rst_hdl_in_handler", in_handler, 1);
      #2 reset = 1'b0; #1;
      chk("rst_hdl_in_handler_clr", in_handler, 0);
      chk("rst_hdl_pending_clr", pending, 0);
      chk("rst_hdl_cause_clr", cause, 0);
      ker = 0; irq = 0;
      @(posedge clk); #1 reset = 1'b1;
      tick(); chk("rst_hdl_quiet", Interrupt, 0);

      // Undef while in kernel mode: error, no trap
      ker = 1; undef = 1;
      tick(); chk("undef_ker_err", err, 1); chk("undef_ker_no_intr", Interrupt, 0);
      undef = 0; ker = 0;
      tick(); chk("err_sticky", err, 1); chk("undef_ker_idle", Interrupt, 0);

      tick();
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
